// File: rtl/canny_pkg.sv
// Shared types for the pixel window generator: pixel width, tap structs and
// the frame-tracking state encoding.
package canny_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // Cross-shaped 3x3 neighbourhood, p5 is the centre.
  typedef struct packed {
    pixel_t p2;
    pixel_t p4;
    pixel_t p5;
    pixel_t p6;
    pixel_t p8;
  } cross_win_t;

  // Diagonal corners, used only when the full 3x3 window is built.
  typedef struct packed {
    pixel_t p1;
    pixel_t p3;
    pixel_t p7;
    pixel_t p9;
  } corner_win_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of storage, addressed by column. The read is combinational
// from the current contents, so a read and a write to the same address in one
// cycle return the old value (read-before-write).
module line_buffer #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data = mem_q[addr];

  // Write the new pixel into its column slot; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/pixel_window_gen.sv
// Raster-scan pixel stream to 3x3 neighbourhood taps for the gradient stage.
// Two line buffers hold rows r-1 and r-2; short column shift registers supply
// the left-hand taps. One output register with pass-through ready:
//   valid/ready: a transfer happens on a rising clk edge where the sender's
//   valid and the receiver's ready are both 1; a sender holding valid keeps its
//   data stable until that edge; in_ready = !out_valid || out_ready.
// Optional macro WINDOW_CORNERS_EN adds out_p1/p3/p7/p9 for the full window.
module pixel_window_gen import canny_pkg::*; #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int PIX_W      = canny_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_p2,
  output logic [PIX_W-1:0] out_p4,
  output logic [PIX_W-1:0] out_p5,
  output logic [PIX_W-1:0] out_p6,
  output logic [PIX_W-1:0] out_p8,
`ifdef WINDOW_CORNERS_EN
  output logic [PIX_W-1:0] out_p1,
  output logic [PIX_W-1:0] out_p3,
  output logic [PIX_W-1:0] out_p7,
  output logic [PIX_W-1:0] out_p9,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_done,
  output logic             dbg_state_o
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  state_t           state_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  logic             accept;
  logic             take;
  logic             win_fire;
  logic             last_pix;
  logic [ROW_W-1:0] pos_row;
  logic [COL_W-1:0] pos_col;

  // Live column of rows r-1 and r-2 read from the line buffers.
  pixel_t           up1_rd;
  pixel_t           up2_rd;

  // Column history: the live column plus these registers give the window
  // width. Row r needs one stage (its live column is in_pix itself).
  pixel_t           cur_d1_q;
  pixel_t           up1_d1_q;
  pixel_t           up1_d2_q;
  pixel_t           up2_d1_q;
`ifdef WINDOW_CORNERS_EN
  pixel_t           cur_d2_q;
  pixel_t           up2_d2_q;
  corner_win_t      corner_q;
`endif

  cross_win_t       win_q;
  logic             out_valid_q;
  logic             frame_done_q;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // Pixels outside a frame are dropped; an sof pixel always starts a frame.
  assign take     = accept && (in_sof || (state_q == ACTIVE));
  assign pos_row  = in_sof ? '0 : row_q;
  assign pos_col  = in_sof ? '0 : col_q;
  assign win_fire = take && (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));
  assign last_pix = take && !in_sof && (row_q == ROW_LAST) && (col_q == COL_LAST);

  // After an sof abort the counters restart at row 0, and rows 0 and 1 of the
  // new frame overwrite every column before any window is formed, so stale
  // history from the aborted frame can never reach the taps.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb_up1 (
    .clk     (clk),
    .wr_en   (take),
    .addr    (pos_col),
    .wr_data (in_pix),
    .rd_data (up1_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb_up2 (
    .clk     (clk),
    .wr_en   (take),
    .addr    (pos_col),
    .wr_data (up1_rd),
    .rd_data (up2_rd)
  );

  // Shift the column history on every stored pixel.
  always_ff @(posedge clk) begin
    if (take) begin
      cur_d1_q <= in_pix;
      up1_d1_q <= up1_rd;
      up1_d2_q <= up1_d1_q;
      up2_d1_q <= up2_rd;
`ifdef WINDOW_CORNERS_EN
      cur_d2_q <= cur_d1_q;
      up2_d2_q <= up2_d1_q;
`endif
    end
  end

  // Frame FSM with raster position counters and the frame_done pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      row_q        <= '0;
      col_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_pix;
      if (take) begin
        if (in_sof) begin
          state_q <= ACTIVE;
          row_q   <= '0;
          col_q   <= COL_W'(1);
        end else if (col_q == COL_LAST) begin
          col_q <= '0;
          if (row_q == ROW_LAST) begin
            row_q   <= '0;
            state_q <= IDLE;
          end else begin
            row_q <= row_q + ROW_W'(1);
          end
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // Output register: load a new window, else drop valid once it is taken.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid_q <= 1'b0;
      win_q       <= '0;
`ifdef WINDOW_CORNERS_EN
      corner_q    <= '0;
`endif
    end else if (win_fire) begin
      out_valid_q <= 1'b1;
      win_q       <= '{p2: up2_d1_q, p4: up1_d2_q, p5: up1_d1_q,
                       p6: up1_rd,   p8: cur_d1_q};
`ifdef WINDOW_CORNERS_EN
      corner_q    <= '{p1: up2_d2_q, p3: up2_rd, p7: cur_d2_q, p9: in_pix};
`endif
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_p2      = win_q.p2;
  assign out_p4      = win_q.p4;
  assign out_p5      = win_q.p5;
  assign out_p6      = win_q.p6;
  assign out_p8      = win_q.p8;
`ifdef WINDOW_CORNERS_EN
  assign out_p1      = corner_q.p1;
  assign out_p3      = corner_q.p3;
  assign out_p7      = corner_q.p7;
  assign out_p9      = corner_q.p9;
`endif
  assign out_valid   = out_valid_q;
  assign frame_done  = frame_done_q;
  assign dbg_state_o = (state_q == ACTIVE);

endmodule

// File: tb/tb_pixel_window_gen.sv
// Bench for pixel_window_gen on a 5x4 image. A frame-image model derives every
// expected window from the accepted pixels; a negedge process compares the DUT
// against it each cycle, and directed scenarios pin specific values.
module tb_pixel_window_gen;

  localparam int W = 5;
  localparam int H = 4;

  typedef struct packed {
    logic [7:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
  } win_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic [7:0] in_pix;
  logic       in_sof;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_p2, out_p4, out_p5, out_p6, out_p8;
`ifdef WINDOW_CORNERS_EN
  logic [7:0] out_p1, out_p3, out_p7, out_p9;
`endif
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;
  logic       dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pixel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_pix     (in_pix),
    .in_sof     (in_sof),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_p2     (out_p2),
    .out_p4     (out_p4),
    .out_p5     (out_p5),
    .out_p6     (out_p6),
    .out_p8     (out_p8),
`ifdef WINDOW_CORNERS_EN
    .out_p1     (out_p1),
    .out_p3     (out_p3),
    .out_p7     (out_p7),
    .out_p9     (out_p9),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int   n_checks = 0;
  int   n_pass   = 0;
  win_t exp_q[$];
  win_t obs_q[$];
  int   img[H][W];
  int   m_active = 0;
  int   m_r = 0;
  int   m_c = 0;
  logic exp_valid = 1'b0;
  logic fd_exp = 1'b0;
  int   fd_count = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic win_t mask(input win_t w);
    win_t m = w;
`ifndef WINDOW_CORNERS_EN
    m.p1 = '0; m.p3 = '0; m.p7 = '0; m.p9 = '0;
`endif
    return m;
  endfunction

  function automatic win_t dut_win();
    win_t w = '0;
    w.p2 = out_p2; w.p4 = out_p4; w.p5 = out_p5; w.p6 = out_p6; w.p8 = out_p8;
`ifdef WINDOW_CORNERS_EN
    w.p1 = out_p1; w.p3 = out_p3; w.p7 = out_p7; w.p9 = out_p9;
`endif
    return w;
  endfunction

  function automatic win_t mk(input int a1, a2, a3, a4, a5, a6, a7, a8, a9);
    win_t w;
    w.p1 = 8'(a1); w.p2 = 8'(a2); w.p3 = 8'(a3);
    w.p4 = 8'(a4); w.p5 = 8'(a5); w.p6 = 8'(a6);
    w.p7 = 8'(a7); w.p8 = 8'(a8); w.p9 = 8'(a9);
    return mask(w);
  endfunction

  function automatic win_t obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return '1;
  endfunction

  // Model of one accepted pixel: place it in the frame image, emit the window
  // centred one row up and one column left when that centre is interior.
  task automatic model_accept(input logic [7:0] pix, input logic sof,
                              output logic new_win, output logic fd);
    win_t w;
    int   r, c;
    new_win = 1'b0;
    fd      = 1'b0;
    if (sof) begin
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++) img[i][j] = -1;
      m_r = 0; m_c = 0; m_active = 1;
    end
    if (m_active == 0) return;
    r = m_r; c = m_c;
    img[r][c] = int'(pix);
    if (r >= 2 && c >= 2) begin
      w = mk(img[r-2][c-2], img[r-2][c-1], img[r-2][c],
             img[r-1][c-2], img[r-1][c-1], img[r-1][c],
             img[r][c-2],   img[r][c-1],   img[r][c]);
      exp_q.push_back(w);
      new_win = 1'b1;
    end
    if (c == W - 1) begin
      m_c = 0;
      if (r == H - 1) begin
        m_r = 0; m_active = 0; fd = 1'b1;
      end else begin
        m_r = r + 1;
      end
    end else begin
      m_c = c + 1;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic nw, nfd, acc;
  always @(negedge clk) begin
    if (!n_rst) begin
      exp_q.delete();
      exp_valid = 1'b0;
      fd_exp    = 1'b0;
      m_active  = 0; m_r = 0; m_c = 0;
    end else begin
      chk("in_ready", {71'b0, in_ready}, {71'b0, (!out_valid || out_ready)});
      chk("out_valid", {71'b0, out_valid}, {71'b0, exp_valid});
      chk("frame_done", {71'b0, frame_done}, {71'b0, fd_exp});
      if (frame_done) fd_count++;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_window", dut_win(), '0);
        else chk("taps", mask(dut_win()), exp_q[0]);
        if (out_ready) begin
          obs_q.push_back(mask(dut_win()));
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
      end
      acc = in_valid && (!exp_valid || out_ready);
      nw  = 1'b0;
      nfd = 1'b0;
      if (acc) model_accept(in_pix, in_sof, nw, nfd);
      fd_exp    = nfd;
      exp_valid = nw || (exp_valid && !out_ready);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] pix, input logic sof);
    int guard = 0;
    in_pix = pix; in_sof = sof; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 72'd0, 72'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  // Pixels first..last-1 of a frame in raster order, value base+10*r+c.
  task automatic send_range(input int base, input int first, input int last);
    for (int i = first; i < last; i++)
      send_pix(8'(base + 10 * (i / W) + (i % W)), i == 0);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    fd_count = 0;
  endtask

  win_t first_w, last_w;

  // ---------------- directed scenarios ----------------
  initial begin
    in_valid = 1'b0; in_pix = '0; in_sof = 1'b0; out_ready = 1'b1;
    first_w = mk(0, 1, 2, 10, 11, 12, 20, 21, 22);
    last_w  = mk(12, 13, 14, 22, 23, 24, 32, 33, 34);

    #2 n_rst = 1'b0;
    #1;
    chk("rst_out_valid", {71'b0, out_valid}, 72'd0);
    chk("rst_frame_done", {71'b0, frame_done}, 72'd0);
    chk("rst_taps", dut_win(), '0);
    chk("rst_in_ready", {71'b0, in_ready}, 72'd1);
    chk("rst_state", {71'b0, dbg_state}, 72'd0);
    @(posedge clk);
    #3 n_rst = 1'b1;
    idle(2);

    // Full frame, downstream always ready.
    clear_obs();
    send_range(0, 0, W * H);
    idle(4);
    chk("s1_count", 72'(obs_q.size()), 72'd6);
    chk("s1_first", obs_at(0), first_w);
    chk("s1_last", obs_at(5), last_w);
    chk("s1_fd", 72'(fd_count), 72'd1);
    chk("s1_idle", {71'b0, dbg_state}, 72'd0);

    // Stray pixels before sof are discarded.
    clear_obs();
    for (int i = 0; i < 3; i++) send_pix(8'd99, 1'b0);
    chk("s2_no_win", 72'(obs_q.size()), 72'd0);
    send_range(0, 0, W * H);
    idle(4);
    chk("s2_count", 72'(obs_q.size()), 72'd6);
    chk("s2_first", obs_at(0), first_w);
    chk("s2_last", obs_at(5), last_w);
    chk("s2_fd", 72'(fd_count), 72'd1);

    // Back-pressure for 3 cycles on the first window.
    clear_obs();
    send_range(0, 0, 13);
    in_pix = 8'd23; in_sof = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("s3_in_ready", {71'b0, in_ready}, 72'd0);
      chk("s3_p5_hold", 72'(out_p5), 72'd11);
      chk("s3_valid_hold", {71'b0, out_valid}, 72'd1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_range(0, 13, W * H);
    idle(4);
    chk("s3_count", 72'(obs_q.size()), 72'd6);
    chk("s3_w0_p5", 72'(obs_at(0).p5), 72'd11);
    chk("s3_w1_p5", 72'(obs_at(1).p5), 72'd12);
    chk("s3_last", obs_at(5), last_w);

    // sof re-asserted at (2,3): frame A aborted, frame B starts there.
    clear_obs();
    send_range(0, 0, 13);
    send_range(100, 0, W * H);
    idle(4);
    chk("s4_count", 72'(obs_q.size()), 72'd7);
    chk("s4_b_first", obs_at(1), mk(100, 101, 102, 110, 111, 112, 120, 121, 122));
    chk("s4_fd", 72'(fd_count), 72'd1);
    chk("s4_exp_empty", 72'(exp_q.size()), 72'd0);

    // Asynchronous reset mid-frame while a window is being shown.
    clear_obs();
    send_range(0, 0, 14);
    chk("s5_pre_valid", {71'b0, out_valid}, 72'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("s5_async_valid", {71'b0, out_valid}, 72'd0);
    chk("s5_async_fd", {71'b0, frame_done}, 72'd0);
    chk("s5_async_taps", dut_win(), '0);
    @(posedge clk);
    #3 n_rst = 1'b1;
    idle(1);
    clear_obs();
    send_range(0, 14, W * H);
    idle(4);
    chk("s5_no_win", 72'(obs_q.size()), 72'd0);
    chk("s5_no_fd", 72'(fd_count), 72'd0);
    send_range(0, 0, W * H);
    idle(4);
    chk("s5_count", 72'(obs_q.size()), 72'd6);
    chk("s5_first", obs_at(0), first_w);
    chk("s5_fd", 72'(fd_count), 72'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
